// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path: FSM encoding,
// framing byte values and frame-size limits.
package eth_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREAMBLE = 3'd1,
      SFD      = 3'd2,
      PAYLOAD  = 3'd3,
      PAD      = 3'd4,
      FCS      = 3'd5,
      IFG      = 3'd6
   } eth_state_t;

   localparam logic [7:0] ETH_PREAMBLE  = 8'h55;
   localparam logic [7:0] ETH_SFD       = 8'hD5;
   localparam int         ETH_MIN_FRAME = 60;
   localparam int         ETH_MAX_FRAME = 1514;

endpackage

// File: rtl/calc_crc32.sv
// Byte-serial Ethernet CRC-32 (reflected 0xEDB88320, init all-ones).
// o_crc32 is the complemented remainder, ready to send LSB byte first.
module calc_crc32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_calc,
   input  logic        i_vl,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc32
);

   localparam logic [31:0] POLY = 32'hEDB88320;

   logic [31:0] crc_reg;
   logic [31:0] crc_next;

   always_comb begin : crc_step
      logic [31:0] c;
      c = crc_reg;
      for (int b = 0; b < 8; b++) begin
         c = {1'b0, c[31:1]} ^ ((c[0] ^ i_data[b]) ? POLY : 32'h0);
      end
      crc_next = c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         crc_reg <= '1;
      end else if (!i_calc) begin
         crc_reg <= '1;
      end else if (i_vl) begin
         crc_reg <= crc_next;
      end
   end

   assign o_crc32 = ~crc_reg;

endmodule

// File: rtl/eth_tx_arb.sv
// Two-source Ethernet TX scheduler: arbitrates between the ARP builder and
// the UDP streamer, then frames the winner with preamble, pad, FCS and IFG.
module eth_tx_arb
   import eth_pkg::*;
#(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = ETH_MIN_FRAME,
   parameter int MAX_FRAME    = ETH_MAX_FRAME,
   parameter int IFG_BYTES    = 12,
   parameter bit RR_EN        = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_stb,
   input  logic       i_req0,
   input  logic [7:0] i_data0,
   input  logic       i_last0,
   output logic       o_rd0,
   output logic       o_gnt0,
   input  logic       i_req1,
   input  logic [7:0] i_data1,
   input  logic       i_last1,
   output logic       o_rd1,
   output logic       o_gnt1,
   output logic [7:0] o_tx_data,
   output logic       o_tx_en,
   output logic       o_busy,
   output logic       o_frame_done,
   output logic       o_trunc,
   output logic [2:0] o_state
);

   localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
   localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME);
   localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);

   eth_state_t  state_reg, state_next;
   logic [10:0] cnt_reg, cnt_next;
   logic        owner_reg, owner_next;
   logic        last_gnt_reg, last_gnt_next;

   logic [7:0]  tx_data_reg;
   logic        tx_en_reg;
   logic        done_reg;
   logic        trunc_reg;
   logic [31:0] fcs_sh_reg;
   logic        fcs_loaded_reg;

   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [1:0]  rd;
   logic [7:0]  sel_data;
   logic        sel_last;
   logic [10:0] cnt_inc;
   logic        pay_end;
   logic        in_frame;
   logic [7:0]  tx_byte;
   logic        tx_en_next;
   logic        crc_calc;
   logic        crc_vl;
   logic [31:0] crc_value;
   logic [31:0] fcs_word;

   assign req      = {i_req1, i_req0};
   assign sel_data = owner_reg ? i_data1 : i_data0;
   assign sel_last = owner_reg ? i_last1 : i_last0;
   assign cnt_inc  = cnt_reg + 11'd1;
   assign pay_end  = sel_last || (cnt_inc == MAX_CNT);
   assign in_frame = (state_reg != IDLE) && (state_reg != IFG);
   // The CRC core clears one cycle into FCS, so the first FCS cycle reads it live.
   assign fcs_word = fcs_loaded_reg ? fcs_sh_reg : crc_value;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign gnt[gi] = in_frame && (owner_reg == 1'(gi));
         assign rd[gi]  = (state_reg == PAYLOAD) && i_stb && gnt[gi];
      end
   endgenerate

   assign o_gnt0       = gnt[0];
   assign o_gnt1       = gnt[1];
   assign o_rd0        = rd[0];
   assign o_rd1        = rd[1];
   assign o_tx_data    = tx_data_reg;
   assign o_tx_en      = tx_en_reg;
   assign o_busy       = (state_reg != IDLE);
   assign o_frame_done = done_reg;
   assign o_trunc      = trunc_reg;
   assign o_state      = state_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         owner_reg    <= 1'b0;
         last_gnt_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         owner_reg    <= owner_next;
         last_gnt_reg <= last_gnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      owner_next    = owner_reg;
      last_gnt_next = last_gnt_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (|req) begin
               state_next = PREAMBLE;
               if (req == 2'b11) begin
                  owner_next = RR_EN ? ~last_gnt_reg : 1'b0;
               end else begin
                  owner_next = req[1];
               end
               last_gnt_next = owner_next;
            end
         end
         PREAMBLE: if (i_stb) begin
            if (cnt_reg == PRE_LAST) begin
               state_next = SFD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         SFD: if (i_stb) begin
            state_next = PAYLOAD;
            cnt_next   = '0;
         end
         PAYLOAD: if (i_stb) begin
            cnt_next = cnt_inc;
            if (pay_end) begin
               if (cnt_inc < MIN_CNT) begin
                  state_next = PAD;
               end else begin
                  state_next = FCS;
                  cnt_next   = '0;
               end
            end
         end
         PAD: if (i_stb) begin
            cnt_next = cnt_inc;
            if (cnt_inc == MIN_CNT) begin
               state_next = FCS;
               cnt_next   = '0;
            end
         end
         FCS: if (i_stb) begin
            cnt_next = cnt_inc;
            if (cnt_reg == 11'd3) begin
               state_next = IFG;
               cnt_next   = '0;
            end
         end
         IFG: if (i_stb) begin
            cnt_next = cnt_inc;
            if (cnt_reg == IFG_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_byte    = 8'h00;
      tx_en_next = 1'b0;
      crc_calc   = 1'b0;
      crc_vl     = 1'b0;
      case (state_reg)
         PREAMBLE: begin
            tx_byte    = ETH_PREAMBLE;
            tx_en_next = 1'b1;
         end
         SFD: begin
            tx_byte    = ETH_SFD;
            tx_en_next = 1'b1;
         end
         PAYLOAD: begin
            tx_byte    = sel_data;
            tx_en_next = 1'b1;
            crc_calc   = 1'b1;
            crc_vl     = i_stb;
         end
         PAD: begin
            tx_en_next = 1'b1;
            crc_calc   = 1'b1;
            crc_vl     = i_stb;
         end
         FCS: begin
            tx_byte    = fcs_word[7:0];
            tx_en_next = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data_reg    <= '0;
         tx_en_reg      <= 1'b0;
         done_reg       <= 1'b0;
         trunc_reg      <= 1'b0;
         fcs_sh_reg     <= '0;
         fcs_loaded_reg <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         trunc_reg <= 1'b0;
         if (state_reg == FCS) begin
            fcs_loaded_reg <= 1'b1;
            if (!fcs_loaded_reg) begin
               fcs_sh_reg <= crc_value;
            end
         end else begin
            fcs_loaded_reg <= 1'b0;
         end
         if (i_stb) begin
            tx_data_reg <= tx_byte;
            tx_en_reg   <= tx_en_next;
            if (state_reg == FCS) begin
               fcs_sh_reg <= {8'h00, fcs_word[31:8]};
            end
            done_reg  <= (state_reg == FCS) && (cnt_reg == 11'd3);
            trunc_reg <= (state_reg == PAYLOAD) && !sel_last && (cnt_inc == MAX_CNT);
         end
      end
   end

   calc_crc32 u_crc (
      .clk     (clk),
      .rst_n   (~rst),
      .i_calc  (crc_calc),
      .i_vl    (crc_vl),
      .i_data  (tx_byte),
      .o_crc32 (crc_value)
   );

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Byte-wide Ethernet transmit scheduler. It shares one TX byte path between two frame sources: src0 is the ARP reply builder and src1 is the UDP/IP payload streamer.
- Sequences each frame as preamble, SFD, source bytes, zero pad, FCS, then inter-frame gap.
- Generates the FCS with the existing calc_crc32 so transmitted frames match the receive path's CRC convention.
- Sits between the frame builders and the PHY TX byte interface.

Parameters:
- PREAMBLE_LEN, 7, count of 0x55 bytes sent before the SFD (0xD5).
- MIN_FRAME, 60, minimum bytes from DA through pad, FCS excluded.
- MAX_FRAME, 1514, maximum bytes from DA through payload; longer frames are truncated.
- IFG_BYTES, 12, idle byte slots after the FCS.
- RR_EN, 1, 1 = round-robin between sources; 0 = fixed priority with src0 winning.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_stb  in  1  byte-slot strobe from PHY; every state advance and every output byte happens only on cycles with i_stb=1
- i_req0  in  1  src0 has a complete frame ready
- i_data0  in  8  src0 current byte
- i_last0  in  1  i_data0 is the final byte of the frame
- o_rd0  out  1  i_data0 consumed this cycle; src0 presents its next byte on the following cycle
- o_gnt0  out  1  src0 owns the TX path
- i_req1, i_data1, i_last1, o_rd1, o_gnt1: same as src0, for src1
- o_tx_data  out  8  TX byte
- o_tx_en  out  1  o_tx_data valid
- o_busy  out  1  FSM is not in IDLE
- o_frame_done  out  1  one-cycle pulse on the stb that emits the last FCS byte
- o_trunc  out  1  one-cycle pulse when MAX_FRAME forces the end of a frame
- o_state  out  3  current FSM state, for debug

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The round-robin pointer is set to favour src0.
  - Reset mid-frame aborts the frame immediately: no FCS, no IFG; the next frame after rst is released starts with a fresh preamble.
- Interface rules:
  - o_tx_data and o_tx_en are registered and update only on i_stb.
  - o_rdN is combinational: o_rdN = (state==PAYLOAD) && i_stb && o_gntN.
- FSM states: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG.
- IDLE:
  - Evaluated every cycle, regardless of i_stb.
  - If either request is high, register the grant and go to PREAMBLE.
  - If both requests are high: with RR_EN=1 the source not granted last wins; with RR_EN=0, src0 wins.
  - o_gntN stays high from the grant through the final FCS byte and drops on entry to IFG.
  - i_reqN is sampled only in IDLE; dropping it mid-frame has no effect.
- PREAMBLE: emit 0x55 on PREAMBLE_LEN strobes, then go to SFD.
- SFD: emit 0xD5 on one strobe, then go to PAYLOAD.
- PAYLOAD:
  - Each stb forwards the granted source's byte to o_tx_data and increments an 11-bit byte counter.
  - When i_lastN is seen: go to PAD if count < MIN_FRAME, otherwise go to FCS.
  - If the count reaches MAX_FRAME without i_lastN, that byte is treated as last and o_trunc pulses. The source is responsible for flushing its remaining bytes after its grant drops.
- PAD: emit 0x00 until the count equals MIN_FRAME, then go to FCS.
- CRC feed to calc_crc32:
  - i_calc is high from the first PAYLOAD byte through the last PAD byte.
  - i_vl = i_stb in PAYLOAD or PAD.
  - i_data is the emitted byte.
  - rst_n of calc_crc32 is driven by ~rst.
  - The CRC is cleared (i_calc low) in IDLE.
- FCS:
  - On entry, latch o_crc32 into a 32-bit shift register.
  - Emit 4 bytes, bits [7:0] first, shifting right by 8 each strobe.
  - Pulse o_frame_done on the 4th byte.
- IFG:
  - o_tx_en=0 for IFG_BYTES strobes, then go to IDLE.
  - Requests raised during IFG wait; the earliest possible grant is the cycle after IFG exits.
- Frames with zero source bytes are illegal: i_lastN must not be high on the first byte with fewer than 14 bytes in the frame. The block does not check this; the bench asserts it.
- Timing:
  - With i_stb held high, the first preamble byte appears 2 cycles after the i_reqN rise.
  - A 60-byte frame occupies 8+60+4+12 = 84 strobes from first preamble byte to IDLE.

Decomposition:
- Shared package eth_pkg holds:
  - state encoding constants (IDLE=0 … IFG=6);
  - byte constants ETH_PREAMBLE=0x55, ETH_SFD=0xD5;
  - ETH_MIN_FRAME and ETH_MAX_FRAME.
- One sub-module: the existing calc_crc32, instantiated unchanged.
- Arbitration logic stays inline; no separate arbiter module.

Test Plan:
- Single src0 request, 42-byte ARP reply, i_stb=1:
  - o_tx_data shows 7x55, D5, 42 source bytes, 18x00, then 4 FCS bytes.
  - The FCS equals the reference CRC32 of those 60 bytes, LSB byte first.
  - o_frame_done pulses once; the next 12 strobes have o_tx_en=0.
- i_req0 and i_req1 high together, RR_EN=1, each with 64-byte frames:
  - Grant order is src0, src1, src0.
  - No pad is added; each frame spans 8+64+4 tx_en strobes.
- Same as the previous scenario with RR_EN=0 and both sources requesting continuously: src0 is granted every time and src1 never.
- src1 frame of 1600 bytes with no i_last1 until byte 1600: o_trunc pulses at byte 1514, and FCS bytes follow immediately.
- i_stb asserted every 5th cycle: output bytes change only on stb cycles, and the frame content is identical to the first scenario.
- rst pulsed during byte 20 of PAYLOAD:
  - o_tx_en=0, o_gnt0=0 and o_busy=0 on the next cycle, with no FCS emitted.
  - A following request produces a correct frame.
